instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 29 ++
 rtl/instr_fetch_wait_timer.sv | 47 ++++
 rtl/instr_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_pkg
// Purpose  : Shared definitions for the instruction fetch unit: FSM state
//            encoding, the NOP instruction and the byte-assembly helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_FETCH_HI = 2'd1;
    localparam state_t ST_FETCH_LO = 2'd2;
    localparam state_t ST_ISSUE    = 2'd3;

    // Substituted as the whole instruction when a byte fetch times out.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // 'first' is the byte read from the fetch address, 'second' from address+1.
    function automatic logic [15:0] assemble_word(input logic [7:0] first,
                                                  input logic [7:0] second,
                                                  input logic       big_endian);
        return big_endian ? {first, second} : {second, first};
    endfunction

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : wait_timer
// Purpose  : Per-byte wait counter for the fetch unit. Counts cycles spent
//            waiting for MEM_ACK and flags the cycle in which the count
//            reaches TIMEOUT without an acknowledge.
// Ports    : CLK        rising-edge clock
//            RESET_L    asynchronous active-low reset
//            i_clr      clear the count (entry into a fetch state)
//            i_run      a fetch state is active this cycle
//            i_ack      memory acknowledge this cycle
//            o_expired  count reaches TIMEOUT this cycle with no acknowledge
// Revision : 1.0 - initial release
// ============================================================================
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic RESET_L,
    input  logic i_clr,
    input  logic i_run,
    input  logic i_ack,
    output logic o_expired
);

    localparam logic [7:0] c_limit = 8'(TIMEOUT);

    logic [7:0] r_count;
    logic [7:0] w_count_inc;

    assign w_count_inc = r_count + 8'd1;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_run && !i_ack) begin
            r_count <= w_count_inc;
        end
    end

    // An acknowledge in the limit cycle wins, so expiry is masked by i_ack.
    assign o_expired = i_run && !i_ack && (w_count_inc == c_limit);

endmodule : wait_timer
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Fetches a 16-bit instruction as two byte reads from an 8-bit
//            instruction memory and presents it to the cpu with a one-cycle
//            active-low strobe. Bytes that time out yield a NOP and set a
//            sticky fault flag.
// Ports    : CLK        rising-edge clock
//            RESET_L    asynchronous active-low reset
//            PC         program counter from cpu (sampled in IDLE only)
//            MEM_ADDR   byte address to instruction memory
//            MEM_REQ    read request, held until acknowledged or timed out
//            MEM_ACK    MEM_RDATA valid this cycle
//            MEM_RDATA  read byte
//            INSTR      assembled instruction
//            EN_L       active-low one-cycle strobe, INSTR valid
//            FAULT      sticky memory timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic        CLK,
    input  logic        RESET_L,
    input  logic [7:0]  PC,
    output logic [7:0]  MEM_ADDR,
    output logic        MEM_REQ,
    input  logic        MEM_ACK,
    input  logic [7:0]  MEM_RDATA,
    output logic [15:0] INSTR,
    output logic        EN_L,
    output logic        FAULT
);

    localparam logic c_big_endian = (BIG_ENDIAN != 0);

    state_t      r_state;
    logic [7:0]  r_fa;
    logic [7:0]  r_byte_first;
    logic [7:0]  r_mem_addr;
    logic        r_mem_req;
    logic [15:0] r_instr;
    logic        r_en_l;
    logic        r_fault;

    logic w_fetching;
    logic w_timer_clr;
    logic w_expired;

    assign w_fetching  = (r_state == ST_FETCH_HI) || (r_state == ST_FETCH_LO);
    // Counter restarts on every entry into a fetch state.
    assign w_timer_clr = (r_state == ST_IDLE) || ((r_state == ST_FETCH_HI) && MEM_ACK);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .i_clr     (w_timer_clr),
        .i_run     (w_fetching),
        .i_ack     (MEM_ACK),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state      <= ST_IDLE;
            r_fa         <= 8'h00;
            r_byte_first <= 8'h00;
            r_mem_addr   <= 8'h00;
            r_mem_req    <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_en_l       <= 1'b1;
            r_fault      <= 1'b0;
        end else begin
            r_en_l <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    // Address goes out straight from PC since FA is loaded on the same edge.
                    r_fa       <= PC;
                    r_mem_addr <= PC;
                    r_mem_req  <= 1'b1;
                    r_state    <= ST_FETCH_HI;
                end
                ST_FETCH_HI: begin
                    if (MEM_ACK) begin
                        r_byte_first <= MEM_RDATA;
                        r_mem_addr   <= r_fa + 8'd1;
                        r_state      <= ST_FETCH_LO;
                    end else if (w_expired) begin
                        r_mem_req <= 1'b0;
                        r_fault   <= 1'b1;
                        r_instr   <= NOP_INSTR;
                        r_en_l    <= 1'b0;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_FETCH_LO: begin
                    if (MEM_ACK) begin
                        r_mem_req <= 1'b0;
                        r_instr   <= assemble_word(r_byte_first, MEM_RDATA, c_big_endian);
                        r_en_l    <= 1'b0;
                        r_state   <= ST_ISSUE;
                    end else if (w_expired) begin
                        r_mem_req <= 1'b0;
                        r_fault   <= 1'b1;
                        r_instr   <= NOP_INSTR;
                        r_en_l    <= 1'b0;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign MEM_ADDR = r_mem_addr;
    assign MEM_REQ  = r_mem_req;
    assign INSTR    = r_instr;
    assign EN_L     = r_en_l;
    assign FAULT    = r_fault;

endmodule : instr_fetch
`default_nettype wire
